mini68k_exc_sequencer: RTL and testbench

- Consumes the exception detector's request (`exception_req`/`vector_num`) and runs the 68000-style exception sequence.
  - Acknowledges the request.
  - Stacks PC and SR on the supervisor stack.
  - Fetches the handler address from the vector table.
  - Hands the core a new PC, SP and SR.
- Also performs the power-on reset fetch of the initial SSP and PC.
- Sits between the exception detector and the core/bus interface unit; owns the 16-bit memory port only while busy.

---
 rtl/mini68k_exc_pkg.sv | 47 ++++
 rtl/mini68k_exc_sequencer_if.sv | 22 ++
 rtl/mini68k_exc_sequencer.sv | 162 ++++++++++++++++
 tb/tb_mini68k_exc_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini68k_exc_pkg.sv
// Shared types and constants for the mini68k exception sequencer:
// FSM states, SR bit layout, reset SR and stack frame offsets.
package mini68k_exc_pkg;

    typedef enum logic [3:0] {
        ST_RST_SSPH,
        ST_RST_SSPL,
        ST_RST_PCH,
        ST_RST_PCL,
        ST_LOAD,
        ST_IDLE,
        ST_LATCH,
        ST_PUSH_PCL,
        ST_PUSH_PCH,
        ST_PUSH_SR,
        ST_FETCH_VH,
        ST_FETCH_VL,
        ST_HALT
    } exc_state_e;

    localparam int SR_T_BIT  = 15;
    localparam int SR_S_BIT  = 13;
    localparam int SR_IPL_HI = 10;
    localparam int SR_IPL_LO = 8;

    localparam logic [15:0] SR_RESET = 16'h2700;

    localparam logic [31:0] FRAME_PCL_OFF = 32'd2;
    localparam logic [31:0] FRAME_PCH_OFF = 32'd4;
    localparam logic [31:0] FRAME_SR_OFF  = 32'd6;

    // Handler SR: supervisor on, trace off; autovectored interrupts raise the mask.
    function automatic logic [15:0] exc_new_sr(input logic [15:0] sr,
                                               input logic [7:0]  vec,
                                               input int          base);
        logic [15:0] r;
        logic [8:0]  lvl;
        r           = sr;
        r[SR_S_BIT] = 1'b1;
        r[SR_T_BIT] = 1'b0;
        lvl         = {1'b0, vec} - base[8:0];
        if (({1'b0, vec} > base[8:0]) && ({1'b0, vec} <= (base[8:0] + 9'd7)))
            r[SR_IPL_HI:SR_IPL_LO] = lvl[2:0];
        return r;
    endfunction

endpackage

// File: rtl/mini68k_exc_sequencer_if.sv
// 16-bit word memory port owned by the exception sequencer while it is busy.
interface mini68k_exc_sequencer_if #(
    parameter int ADDR_W = 24
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ack;
    logic              mem_err;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack, mem_err
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack, mem_err
    );
endinterface

// File: rtl/mini68k_exc_sequencer.sv
// Exception sequencer: power-on SSP/PC fetch, 68000-style PC/SR stacking and
// handler vector fetch over a 16-bit memory port, then a one-cycle context load.
module mini68k_exc_sequencer
    import mini68k_exc_pkg::*;
#(
    parameter int ADDR_W       = 24,
    parameter int INT_VEC_BASE = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exception_req,
    input  logic [7:0]  vector_num,
    output logic        exception_ack,
    input  logic        cpu_boundary,
    input  logic [31:0] cur_pc,
    input  logic [15:0] cur_sr,
    input  logic [31:0] cur_ssp,
    output logic        busy,
    mini68k_exc_sequencer_if.master mem,
    output logic        load_ctx,
    output logic [31:0] new_pc,
    output logic [31:0] new_ssp,
    output logic [15:0] new_sr,
    output logic        halted
);

    exc_state_e        state_q, state_d;
    logic              run_q;
    logic [7:0]        vec_q;
    logic [31:0]       pc_q;
    logic [31:0]       sp_q;
    logic [15:0]       sr_q;
    logic [31:0]       new_pc_q, new_ssp_q;
    logic [15:0]       new_sr_q;

    logic              is_mem, we;
    logic              req, xfer_ok, xfer_err;
    logic [ADDR_W-1:0] addr_w;
    logic [15:0]       wdata;

    // run_q keeps the port quiet during the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST_SSPH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    assign req      = is_mem && run_q;
    assign xfer_err = req && mem.mem_err;
    assign xfer_ok  = req && mem.mem_ack && !mem.mem_err;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (exception_req && cpu_boundary) state_d = ST_LATCH;
            ST_LATCH: state_d = ST_PUSH_PCL;
            ST_LOAD:  state_d = ST_IDLE;
            ST_HALT:  state_d = ST_HALT;
            default: begin
                if (xfer_err) begin
                    state_d = ST_HALT;
                end else if (xfer_ok) begin
                    unique case (state_q)
                        ST_RST_SSPH: state_d = ST_RST_SSPL;
                        ST_RST_SSPL: state_d = ST_RST_PCH;
                        ST_RST_PCH:  state_d = ST_RST_PCL;
                        ST_RST_PCL:  state_d = ST_LOAD;
                        ST_PUSH_PCL: state_d = ST_PUSH_PCH;
                        ST_PUSH_PCH: state_d = ST_PUSH_SR;
                        ST_PUSH_SR:  state_d = ST_FETCH_VH;
                        ST_FETCH_VH: state_d = ST_FETCH_VL;
                        ST_FETCH_VL: state_d = ST_LOAD;
                        default:     state_d = ST_HALT;
                    endcase
                end
            end
        endcase
    end

    // Address and data derive only from state and captured registers, so they
    // hold steady for as long as a transfer waits.
    always_comb begin
        is_mem = 1'b0;
        we     = 1'b0;
        addr_w = '0;
        wdata  = '0;
        unique case (state_q)
            ST_RST_SSPH: begin is_mem = 1'b1; addr_w = ADDR_W'(0); end
            ST_RST_SSPL: begin is_mem = 1'b1; addr_w = ADDR_W'(2); end
            ST_RST_PCH:  begin is_mem = 1'b1; addr_w = ADDR_W'(4); end
            ST_RST_PCL:  begin is_mem = 1'b1; addr_w = ADDR_W'(6); end
            ST_PUSH_PCL: begin
                is_mem = 1'b1; we = 1'b1; wdata = pc_q[15:0];
                addr_w = sp_q[ADDR_W-1:0] - ADDR_W'(FRAME_PCL_OFF);
            end
            ST_PUSH_PCH: begin
                is_mem = 1'b1; we = 1'b1; wdata = pc_q[31:16];
                addr_w = sp_q[ADDR_W-1:0] - ADDR_W'(FRAME_PCH_OFF);
            end
            ST_PUSH_SR: begin
                is_mem = 1'b1; we = 1'b1; wdata = sr_q;
                addr_w = sp_q[ADDR_W-1:0] - ADDR_W'(FRAME_SR_OFF);
            end
            ST_FETCH_VH: begin is_mem = 1'b1; addr_w = ADDR_W'({vec_q, 2'b00}); end
            ST_FETCH_VL: begin is_mem = 1'b1; addr_w = ADDR_W'({vec_q, 2'b00}) + ADDR_W'(2); end
            default: ;
        endcase
    end

    assign mem.mem_req   = req;
    assign mem.mem_we    = we;
    assign mem.mem_addr  = addr_w & ~ADDR_W'(1);
    assign mem.mem_wdata = wdata;

    assign busy          = run_q && (state_q != ST_IDLE);
    assign exception_ack = (state_q == ST_LATCH);
    assign load_ctx      = (state_q == ST_LOAD);
    assign halted        = (state_q == ST_HALT);

    always_ff @(posedge clk) begin
        if (state_q == ST_LATCH) begin
            vec_q <= vector_num;
            pc_q  <= cur_pc;
            sr_q  <= cur_sr;
            sp_q  <= cur_ssp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_pc_q  <= '0;
            new_ssp_q <= '0;
            new_sr_q  <= '0;
        end else if (xfer_ok) begin
            unique case (state_q)
                ST_RST_SSPH: new_ssp_q[31:16] <= mem.mem_rdata;
                ST_RST_SSPL: new_ssp_q[15:0]  <= mem.mem_rdata;
                ST_RST_PCH:  new_pc_q[31:16]  <= mem.mem_rdata;
                ST_RST_PCL: begin
                    new_pc_q[15:0] <= mem.mem_rdata;
                    new_sr_q       <= SR_RESET;
                end
                ST_PUSH_SR:  new_ssp_q <= sp_q - FRAME_SR_OFF;
                ST_FETCH_VH: new_pc_q[31:16] <= mem.mem_rdata;
                ST_FETCH_VL: begin
                    new_pc_q[15:0] <= mem.mem_rdata;
                    new_sr_q       <= exc_new_sr(sr_q, vec_q, INT_VEC_BASE);
                end
                default: ;
            endcase
        end
    end

    assign new_pc  = new_pc_q;
    assign new_ssp = new_ssp_q;
    assign new_sr  = new_sr_q;

endmodule

// File: tb/tb_mini68k_exc_sequencer.sv
// Randomized bench for mini68k_exc_sequencer against a transaction-level model
// of the reset fetch and exception frame, with a wait-state/error memory responder.
module tb_mini68k_exc_sequencer;

    localparam int ADDR_W = 24;

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [15:0] data;
    } xfer_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ssp;
        logic [15:0] sr;
    } ld_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exception_req, cpu_boundary, exception_ack;
    logic [7:0]  vector_num;
    logic [31:0] cur_pc, cur_ssp;
    logic [15:0] cur_sr;
    logic        busy, load_ctx, halted;
    logic [31:0] new_pc, new_ssp;
    logic [15:0] new_sr;

    mini68k_exc_sequencer_if #(.ADDR_W(ADDR_W)) mif ();

    mini68k_exc_sequencer #(.ADDR_W(ADDR_W), .INT_VEC_BASE(24)) dut (
        .clk(clk), .rst_n(rst_n),
        .exception_req(exception_req), .vector_num(vector_num),
        .exception_ack(exception_ack), .cpu_boundary(cpu_boundary),
        .cur_pc(cur_pc), .cur_sr(cur_sr), .cur_ssp(cur_ssp),
        .busy(busy), .mem(mif),
        .load_ctx(load_ctx), .new_pc(new_pc), .new_ssp(new_ssp),
        .new_sr(new_sr), .halted(halted)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] memw [int];
    xfer_t       exp_q[$];
    ld_t         exp_ld[$];
    int          extra_x, extra_l;
    int          wait_states, err_at, xfer_idx, wcnt;
    logic        h_we;
    logic [23:0] h_addr;
    logic [15:0] h_wdata;
    xfer_t       rsp_f;
    ld_t         mon_l;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd(input int a);
        return memw.exists(a) ? memw[a] : 16'h0000;
    endfunction

    function automatic logic [23:0] a24(input logic [31:0] a);
        return {a[23:1], 1'b0};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory responder: holds each transfer for wait_states cycles, then acks
    // (or raises err together with ack on the selected transfer).
    initial begin
        mif.mem_ack = 1'b0; mif.mem_err = 1'b0; mif.mem_rdata = 16'h0;
        wcnt = 0; xfer_idx = 0;
        forever begin
            @(negedge clk);
            mif.mem_ack = 1'b0;
            mif.mem_err = 1'b0;
            if (mif.mem_req !== 1'b1) begin
                wcnt = 0;
            end else begin
                if (wcnt == 0) begin
                    h_we = mif.mem_we; h_addr = mif.mem_addr; h_wdata = mif.mem_wdata;
                end else begin
                    chk("hold_we", mif.mem_we, h_we);
                    chk("hold_addr", mif.mem_addr, h_addr);
                    chk("hold_wdata", mif.mem_wdata, h_wdata);
                end
                if (wcnt >= wait_states) begin
                    if (exp_q.size() == 0) begin
                        extra_x++;
                    end else begin
                        rsp_f = exp_q.pop_front();
                        chk("xfer_we", h_we, rsp_f.we);
                        chk("xfer_addr", h_addr, rsp_f.addr);
                        if (rsp_f.we) chk("xfer_wdata", h_wdata, rsp_f.data);
                    end
                    mif.mem_ack   = 1'b1;
                    mif.mem_rdata = rd(int'(h_addr));
                    if (xfer_idx == err_at) mif.mem_err = 1'b1;
                    xfer_idx++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    initial begin
        extra_l = 0;
        forever begin
            @(negedge clk);
            if (load_ctx === 1'b1) begin
                if (exp_ld.size() == 0) begin
                    extra_l++;
                end else begin
                    mon_l = exp_ld.pop_front();
                    chk("ld_pc", new_pc, mon_l.pc);
                    chk("ld_ssp", new_ssp, mon_l.ssp);
                    chk("ld_sr", new_sr, mon_l.sr);
                end
            end
        end
    end

    task automatic model_reset();
        ld_t l;
        for (int a = 0; a < 8; a += 2) exp_q.push_back('{1'b0, 24'(a), 16'h0});
        l.ssp = {rd(0), rd(2)};
        l.pc  = {rd(4), rd(6)};
        l.sr  = 16'h2700;
        exp_ld.push_back(l);
    endtask

    // Exception frame: PC low, PC high, SR pushed downward, then the vector pair.
    task automatic model_exc(input int vec, input logic [31:0] pc, input logic [15:0] sr,
                             input logic [31:0] ssp, input int nxf);
        xfer_t f[5];
        ld_t   l;
        int    s;
        f[0] = '{1'b1, a24(ssp - 32'd2), pc[15:0]};
        f[1] = '{1'b1, a24(ssp - 32'd4), pc[31:16]};
        f[2] = '{1'b1, a24(ssp - 32'd6), sr};
        f[3] = '{1'b0, a24(32'(vec * 4)), 16'h0};
        f[4] = '{1'b0, a24(32'(vec * 4 + 2)), 16'h0};
        for (int i = 0; i < nxf; i++) exp_q.push_back(f[i]);
        if (nxf == 5) begin
            s = (int'(sr) | 'h2000) & 'h7FFF;
            if (vec > 24 && vec <= 31) s = (s & 'hF8FF) | ((vec - 24) * 256);
            l.pc  = {rd(vec * 4), rd(vec * 4 + 2)};
            l.ssp = ssp - 32'd6;
            l.sr  = 16'(s);
            exp_ld.push_back(l);
        end
    endtask

    task automatic check_reset_outs();
        chk("rst_ctl", {busy, exception_ack, load_ctx, halted, mif.mem_req, mif.mem_we}, 0);
        chk("rst_addr", mif.mem_addr, 0);
        chk("rst_wdata", mif.mem_wdata, 0);
        chk("rst_new_pc", new_pc, 0);
        chk("rst_new_ssp", new_ssp, 0);
        chk("rst_new_sr", new_sr, 0);
    endtask

    task automatic scen_end();
        chk("xfer_left", exp_q.size(), 0);
        chk("xfer_extra", extra_x, 0);
        chk("load_left", exp_ld.size(), 0);
        chk("load_extra", extra_l, 0);
    endtask

    task automatic wait_load_done();
        for (int i = 0; i < 300 && exp_ld.size() != 0; i++) tick();
        chk("load_done", exp_ld.size(), 0);
    endtask

    task automatic reset_fetch();
        wait_states = 0;
        err_at      = -1;
        exp_q.delete();
        exp_ld.delete();
        extra_x = 0;
        extra_l = 0;
        model_reset();
        rst_n = 1'b1;
        chk("rst_first_req", mif.mem_req, 0);
        wait_load_done();
        tick();
        chk("rst_idle_busy", busy, 0);
        scen_end();
    endtask

    task automatic exc_start(input int vec, input logic [31:0] pc, input logic [15:0] sr,
                             input logic [31:0] ssp, input int bdelay, input int ws,
                             input int nxf);
        wait_states = ws;
        err_at      = (nxf < 5) ? xfer_idx + nxf - 1 : -1;
        model_exc(vec, pc, sr, ssp, nxf);
        vector_num    = 8'(vec);
        cur_pc        = pc;
        cur_sr        = sr;
        cur_ssp       = ssp;
        exception_req = 1'b1;
        cpu_boundary  = 1'b0;
        for (int i = 0; i < bdelay; i++) begin
            tick();
            chk("gate_ack", exception_ack, 0);
            chk("gate_busy", busy, 0);
        end
        cpu_boundary = 1'b1;
        tick();
        chk("ack_pulse", exception_ack, 1);
        chk("latch_busy", busy, 1);
        exception_req = 1'b0;
        cpu_boundary  = 1'b0;
        tick();
        chk("ack_once", exception_ack, 0);
        chk("stack_busy", busy, 1);
    endtask

    task automatic exc_finish();
        wait_load_done();
        tick();
        chk("idle_busy", busy, 0);
        scen_end();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          vec, ws, mode;
        logic [31:0] ssp;
        logic        found;

        rst_n = 1'b0;
        exception_req = 1'b0; cpu_boundary = 1'b0; vector_num = 8'h0;
        cur_pc = '0; cur_sr = '0; cur_ssp = '0;
        wait_states = 0; err_at = -1; extra_x = 0;
        memw[0] = 16'h0001; memw[2] = 16'h0000; memw[4] = 16'h0000; memw[6] = 16'h0400;
        repeat (3) tick();
        check_reset_outs();
        reset_fetch();

        // Illegal instruction with a 10-cycle wait for the instruction boundary.
        memw['h10] = 16'h0000; memw['h12] = 16'h2000;
        exc_start(4, 32'h0000_1234, 16'h0000, 32'h0001_0000, 10, 0, 5);
        exc_finish();

        // Level-5 autovector interrupt.
        memw['h74] = 16'h0000; memw['h76] = 16'h0500;
        exc_start(29, $urandom, 16'h8300, 32'h0002_0000, 0, 1, 5);
        exc_finish();

        for (int n = 0; n < 24; n++) begin
            mode = $urandom_range(0, 2);
            if (mode == 0) vec = $urandom_range(0, 255);
            else if (mode == 1) vec = $urandom_range(23, 33);
            else vec = $urandom_range(2, 63);
            memw[vec * 4]     = 16'($urandom);
            memw[vec * 4 + 2] = 16'($urandom);
            exc_start(vec, $urandom, 16'($urandom), $urandom, $urandom_range(0, 3),
                      $urandom_range(0, 3), 5);
            exc_finish();
        end

        // Wait states on the writes, bus error on the first vector read.
        memw[32] = 16'h1111; memw[34] = 16'h2222;
        exc_start(8, $urandom, 16'($urandom), 32'h0003_0000, 0, 3, 4);
        for (int i = 0; i < 200 && halted !== 1'b1; i++) tick();
        chk("halted_set", halted, 1);
        exception_req = 1'b1;
        cpu_boundary  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_sticky", halted, 1);
            chk("halt_busy", busy, 1);
            chk("halt_req", mif.mem_req, 0);
            chk("halt_no_ack", exception_ack, 0);
        end
        scen_end();
        rst_n = 1'b0;
        #1;
        check_reset_outs();
        exception_req = 1'b0;
        cpu_boundary  = 1'b0;
        tick();
        memw[0] = 16'($urandom); memw[2] = 16'($urandom);
        memw[4] = 16'($urandom); memw[6] = 16'($urandom);
        reset_fetch();

        // Reset asserted while the PC high word is being pushed.
        vec = $urandom_range(2, 63);
        ssp = $urandom & 32'hFFFF_FFFE;
        exc_start(vec, $urandom, 16'($urandom), ssp, 0, 2, 5);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (mif.mem_req === 1'b1 && mif.mem_we === 1'b1 && mif.mem_addr === a24(ssp - 32'd4))
                found = 1'b1;
            else
                tick();
        end
        chk("pch_seen", found, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outs();
        tick();
        check_reset_outs();
        chk("abort_no_load", extra_l, 0);
        memw[0] = 16'($urandom); memw[2] = 16'($urandom);
        memw[4] = 16'($urandom); memw[6] = 16'($urandom);
        reset_fetch();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
